// File: rtl/flop_chain_pkg.sv
// Shared mode encodings, per-stage next-value selects and sizing helper
// for the flop_chain_pipe register chain.
package flop_chain_pkg;

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_SHIFT  = 2'b01;
  localparam logic [1:0] MODE_LOAD   = 2'b10;
  localparam logic [1:0] MODE_ROTATE = 2'b11;

  typedef enum logic [1:0] {
    SEL_KEEP = 2'b00,
    SEL_PREV = 2'b01,
    SEL_LOAD = 2'b10
  } stage_sel_t;

  // Wide enough to count 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flop_chain_stage.sv
// One chain stage: WIDTH-bit data register plus valid bit, selecting
// between keep, previous stage and parallel load each edge.
module flop_chain_stage
  import flop_chain_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      case (sel)
        SEL_PREV: begin
          data  <= prev_data;
          valid <= prev_valid;
        end
        SEL_LOAD: begin
          data  <= load_value;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/flop_chain_pipe.sv
// WIDTH x DEPTH register chain with per-stage valids and an incrementally
// maintained occupancy count; modes hold, shift, parallel load and rotate.
module flop_chain_pipe
  import flop_chain_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int OCC_W = occ_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       a,
  input  logic                   a_valid,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  output logic [WIDTH-1:0]       z,
  output logic                   z_valid,
  output logic [DEPTH*WIDTH-1:0] stages,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [OCC_W-1:0]       occupancy
);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic             valid_q [DEPTH];
  logic [1:0]       sel;
  logic [WIDTH-1:0] head_data;
  logic             head_valid;

  always_comb begin
    sel = SEL_KEEP;
    case (mode)
      MODE_SHIFT, MODE_ROTATE: sel = SEL_PREV;
      MODE_LOAD:               sel = SEL_LOAD;
      default:                 sel = SEL_KEEP;
    endcase
  end

  // Stage 0 takes the serial input when shifting and the tail when rotating;
  // with DEPTH=1 the tail is stage 0 itself, so rotate degenerates to hold.
  always_comb begin
    head_data  = a;
    head_valid = a_valid;
    if (mode == MODE_ROTATE) begin
      head_data  = data_q[DEPTH-1];
      head_valid = valid_q[DEPTH-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      flop_chain_stage #(.WIDTH(WIDTH)) u_stage (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .prev_data  (head_data),
        .prev_valid (head_valid),
        .load_value (load_data[0 +: WIDTH]),
        .data       (data_q[0]),
        .valid      (valid_q[0])
      );
    end else begin : g_body
      flop_chain_stage #(.WIDTH(WIDTH)) u_stage (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .prev_data  (data_q[i-1]),
        .prev_valid (valid_q[i-1]),
        .load_value (load_data[i*WIDTH +: WIDTH]),
        .data       (data_q[i]),
        .valid      (valid_q[i])
      );
    end
  end

  always_comb begin
    stages      = '0;
    stage_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stages[i*WIDTH +: WIDTH] = data_q[i];
      stage_valid[i]           = valid_q[i];
    end
  end

  assign z       = data_q[DEPTH-1];
  assign z_valid = valid_q[DEPTH-1];

  // Only shift and load move the count; rotate and hold preserve the valid set.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      case (mode)
        MODE_LOAD: occupancy <= OCC_W'(DEPTH);
        MODE_SHIFT: begin
          if (a_valid && !valid_q[DEPTH-1])
            occupancy <= occupancy + OCC_W'(1);
          else if (!a_valid && valid_q[DEPTH-1])
            occupancy <= occupancy - OCC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
